// File: rtl/poly_root_search_if.sv
// Operand load / result bus shared by the root search core and its front end.
// Carries the go strobe, switch data, and the status and result outputs.
// The master drives go/data_in; the slave (core) drives everything else.
interface poly_root_search_if #(
  parameter int DATA_W = 8
);
  logic              go;
  logic [DATA_W-1:0] data_in;
  logic [1:0]        load_sel;
  logic              busy;
  logic              done;
  logic              found;
  logic [DATA_W-1:0] x_result;

  modport master (
    output go,
    output data_in,
    input  load_sel,
    input  busy,
    input  done,
    input  found,
    input  x_result
  );

  modport slave (
    input  go,
    input  data_in,
    output load_sel,
    output busy,
    output done,
    output found,
    output x_result
  );
endinterface

// File: rtl/poly_root_search.sv
// Finds the smallest x with A*x^2 + B*x + C == Y (mod 2^DATA_W) by linear search.
// Latency: 5 cycles per candidate; done at cycle 5k+5 for root k, 5*2^DATA_W if none.
// No backpressure: go is a level press/release handshake, ignored while searching.
module poly_root_search #(
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               resetn,
  poly_root_search_if.slave  bus
);

  typedef enum logic [3:0] {
    S_LOAD_A      = 4'd0,
    S_LOAD_A_WAIT = 4'd1,
    S_LOAD_B      = 4'd2,
    S_LOAD_B_WAIT = 4'd3,
    S_LOAD_C      = 4'd4,
    S_LOAD_C_WAIT = 4'd5,
    S_LOAD_Y      = 4'd6,
    S_LOAD_Y_WAIT = 4'd7,
    S_EVAL_0      = 4'd8,
    S_EVAL_1      = 4'd9,
    S_EVAL_2      = 4'd10,
    S_EVAL_3      = 4'd11,
    S_CHECK       = 4'd12,
    S_DONE        = 4'd13,
    S_DONE_WAIT   = 4'd14
  } state_t;

  localparam logic [DATA_W-1:0] X_LAST = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] X_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  state_t            state_d;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] c_q;
  logic [DATA_W-1:0] y_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] x_result_q;
  logic              found_q;
  logic              done_q;
  logic              busy_q;
  logic [1:0]        load_sel_d;

  logic              hit;
  logic              last_x;

  assign hit    = (acc_q == y_q);
  assign last_x = (x_q == X_LAST);

  // State register; reset wins over everything, including an active search.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_LOAD_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: press/release walk through the loads, then the
  // five-step evaluate/check loop, then wait for acknowledgement.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD_A:      if (bus.go)  state_d = S_LOAD_A_WAIT;
      S_LOAD_A_WAIT: if (!bus.go) state_d = S_LOAD_B;
      S_LOAD_B:      if (bus.go)  state_d = S_LOAD_B_WAIT;
      S_LOAD_B_WAIT: if (!bus.go) state_d = S_LOAD_C;
      S_LOAD_C:      if (bus.go)  state_d = S_LOAD_C_WAIT;
      S_LOAD_C_WAIT: if (!bus.go) state_d = S_LOAD_Y;
      S_LOAD_Y:      if (bus.go)  state_d = S_LOAD_Y_WAIT;
      S_LOAD_Y_WAIT: if (!bus.go) state_d = S_EVAL_0;
      S_EVAL_0:      state_d = S_EVAL_1;
      S_EVAL_1:      state_d = S_EVAL_2;
      S_EVAL_2:      state_d = S_EVAL_3;
      S_EVAL_3:      state_d = S_CHECK;
      S_CHECK: begin
        if (hit || last_x) begin
          state_d = S_DONE;
        end else begin
          state_d = S_EVAL_0;
        end
      end
      S_DONE:        if (bus.go)  state_d = S_DONE_WAIT;
      S_DONE_WAIT:   if (!bus.go) state_d = S_LOAD_A;
      default:       state_d = S_LOAD_A;
    endcase
  end

  // Operand select indicator for the front end; zero outside the load phase.
  always_comb begin
    load_sel_d = 2'd0;
    case (state_q)
      S_LOAD_A, S_LOAD_A_WAIT: load_sel_d = 2'd0;
      S_LOAD_B, S_LOAD_B_WAIT: load_sel_d = 2'd1;
      S_LOAD_C, S_LOAD_C_WAIT: load_sel_d = 2'd2;
      S_LOAD_Y, S_LOAD_Y_WAIT: load_sel_d = 2'd3;
      default:                 load_sel_d = 2'd0;
    endcase
  end

  // Operand capture: the register follows data_in every edge in its load
  // state, so the value kept is the one present when go is first seen.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      y_q <= '0;
    end else begin
      case (state_q)
        S_LOAD_A: a_q <= bus.data_in;
        S_LOAD_B: b_q <= bus.data_in;
        S_LOAD_C: c_q <= bus.data_in;
        S_LOAD_Y: y_q <= bus.data_in;
        default: ;
      endcase
    end
  end

  // Horner datapath and candidate/result tracking; every step wraps at DATA_W.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x_q        <= '0;
      acc_q      <= '0;
      x_result_q <= '0;
      found_q    <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD_Y_WAIT: begin
          if (!bus.go) begin
            x_q        <= '0;
            found_q    <= 1'b0;
            x_result_q <= '0;
          end
        end
        S_EVAL_0: acc_q <= a_q * x_q;
        S_EVAL_1: acc_q <= acc_q + b_q;
        S_EVAL_2: acc_q <= acc_q * x_q;
        S_EVAL_3: acc_q <= acc_q + c_q;
        S_CHECK: begin
          if (hit) begin
            x_result_q <= x_q;
            found_q    <= 1'b1;
          end else if (last_x) begin
            x_result_q <= x_q;
            found_q    <= 1'b0;
          end else begin
            x_q <= x_q + X_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == S_EVAL_0) || (state_d == S_EVAL_1) ||
                (state_d == S_EVAL_2) || (state_d == S_EVAL_3) ||
                (state_d == S_CHECK);
      done_q <= (state_d == S_DONE) || (state_d == S_DONE_WAIT);
    end
  end

  assign bus.load_sel = load_sel_d;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.found    = found_q;
  assign bus.x_result = x_result_q;

endmodule

// File: tb/tb_poly_root_search.sv
// Table-driven and randomized check of poly_root_search against a brute-force model.
module tb_poly_root_search;

  localparam int DATA_W = 8;
  localparam int NO_ROOT_CYCLES = 5 * (1 << DATA_W);

  logic clk;
  logic resetn;

  poly_root_search_if #(.DATA_W(DATA_W)) bus ();

  poly_root_search #(.DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int    a;
    int    b;
    int    c;
    int    y;
    int    exp_found;
    int    exp_x;
    int    exp_done;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Brute force over all x using plain integer arithmetic.
  function automatic void ref_search(input int a, input int b, input int c, input int y,
                                     output int f, output int xr, output int dc);
    f  = 0;
    xr = (1 << DATA_W) - 1;
    dc = NO_ROOT_CYCLES;
    for (int x = 0; x < (1 << DATA_W); x++) begin
      if (((a * x * x + b * x + c) % (1 << DATA_W)) == y) begin
        f  = 1;
        xr = x;
        dc = 5 * x + 5;
        return;
      end
    end
  endfunction

  task automatic load_operand(input int v, input int sel);
    @(negedge clk);
    check($sformatf("load_sel_%0d", sel), int'(bus.load_sel), sel);
    bus.data_in = v[DATA_W-1:0];
    bus.go      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.go      = 1'b0;
    bus.data_in = DATA_W'($urandom);
    @(posedge clk);
  endtask

  task automatic load_all(input int a, input int b, input int c, input int y);
    load_operand(a, 0);
    load_operand(b, 1);
    load_operand(c, 2);
    load_operand(y, 3);
  endtask

  // Count cycles from the first evaluation cycle until done is seen.
  task automatic run_search(output int done_cyc, output int busy_cnt);
    done_cyc = -1;
    busy_cnt = 0;
    for (int n = 0; n < NO_ROOT_CYCLES + 50; n++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cyc = n;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
  endtask

  task automatic ack_done();
    bus.go = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.go = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_case(input string nm, input int a, input int b, input int c, input int y,
                          input int ef, input int ex, input int ed);
    int dc, bc;
    load_all(a, b, c, y);
    run_search(dc, bc);
    check({nm, "_done_cycle"}, dc, ed);
    check({nm, "_busy_cycles"}, bc, ed);
    check({nm, "_found"}, int'(bus.found), ef);
    check({nm, "_x_result"}, int'(bus.x_result), ex);
    ack_done();
    check({nm, "_ack_done_low"}, int'(bus.done), 0);
    check({nm, "_ack_load_sel"}, int'(bus.load_sel), 0);
    check({nm, "_hold_found"}, int'(bus.found), ef);
    check({nm, "_hold_x"}, int'(bus.x_result), ex);
  endtask

  initial begin
    int f, xr, dc, bc;
    int a, b, c, y, xr0;

    vecs[0] = '{"root3",   1, 0, 0, 9,    1, 3,   20};
    vecs[1] = '{"const",   0, 0, 5, 5,    1, 0,   5};
    vecs[2] = '{"horner",  2, 3, 1, 8'h2D, 1, 4,  25};
    vecs[3] = '{"noroot",  0, 2, 0, 1,    0, 255, NO_ROOT_CYCLES};

    resetn      = 1'b0;
    bus.go      = 1'b0;
    bus.data_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_found", int'(bus.found), 0);
    check("rst_x", int'(bus.x_result), 0);
    check("rst_load_sel", int'(bus.load_sel), 0);
    resetn = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 4; i++) begin
      run_case(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].y,
               vecs[i].exp_found, vecs[i].exp_x, vecs[i].exp_done);
    end

    // Mid-search reset with go held high.
    load_all(0, 2, 0, 1);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      bus.go = 1'b1;
      if (n == 50) check("midrun_done_low", int'(bus.done), 0);
    end
    @(negedge clk);
    check("midrun_busy", int'(bus.busy), 1);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mrst_busy", int'(bus.busy), 0);
    check("mrst_done", int'(bus.done), 0);
    check("mrst_found", int'(bus.found), 0);
    check("mrst_x", int'(bus.x_result), 0);
    check("mrst_load_sel", int'(bus.load_sel), 0);
    resetn = 1'b1;
    bus.go = 1'b0;
    @(posedge clk);
    run_case("after_rst", 1, 0, 0, 9, 1, 3, 20);

    // Y held with go for several cycles while data_in moves: first value wins.
    load_operand(0, 0);
    load_operand(0, 1);
    load_operand(7, 2);
    @(negedge clk);
    bus.data_in = 8'd3;
    @(negedge clk);
    bus.data_in = 8'd7;
    bus.go      = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.data_in = 8'd9 + k[DATA_W-1:0];
    end
    bus.go = 1'b0;
    @(posedge clk);
    run_search(dc, bc);
    check("yhold_done_cycle", dc, 5);
    check("yhold_found", int'(bus.found), 1);
    check("yhold_x", int'(bus.x_result), 0);
    ack_done();

    // Randomized operands against the brute-force model.
    for (int i = 0; i < 8; i++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      c = $urandom_range(0, 255);
      if (i == 0) begin
        a = 0;
        b = 0;
      end
      if (i % 2 == 1) begin
        xr0 = $urandom_range(0, 255);
        y = (a * xr0 * xr0 + b * xr0 + c) % 256;
      end else begin
        y = $urandom_range(0, 255);
      end
      ref_search(a, b, c, y, f, xr, dc);
      run_case($sformatf("rand%0d", i), a, b, c, y, f, xr, dc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
